// File: rtl/video_cfg_bank_if.sv
// Purpose: register-bus and config-update handshake bundle for video_cfg_bank.
// Signals:
//   reg_wdata       32-bit MCU write data
//   reg_rdata       32-bit MCU read data (combinational from reg_addr)
//   reg_addr        6-bit byte address, [1:0] ignored
//   reg_wstrobe     one-cycle write strobe
//   cfg_update_req  level from the bank: active set changed, resample it
//   cfg_update_ack  acknowledge from the timing generator (same clock domain)
// Modports:
//   slave  - the register bank
//   master - the environment driving it (MCU bus plus timing generator)
interface video_cfg_bank_if;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [5:0]  reg_addr;
    logic        reg_wstrobe;
    logic        cfg_update_req;
    logic        cfg_update_ack;

    modport slave (
        input  reg_wdata, reg_addr, reg_wstrobe, cfg_update_ack,
        output reg_rdata, cfg_update_req
    );

    modport master (
        output reg_wdata, reg_addr, reg_wstrobe, cfg_update_ack,
        input  reg_rdata, cfg_update_req
    );
endinterface

// File: rtl/video_cfg_bank.sv
// Purpose: video timing/config register file with N_PROF shadow profiles and a
// frame-synchronous commit engine. The MCU edits shadow profiles; a commit copies
// one profile into the active set at the next VIDC flyback rise (or immediately),
// then a 4-phase req/ack tells the timing generator to resample.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   bus (slave)             register bus and cfg_update req/ack handshake
//   i_sync_flybk            asynchronous flyback level from VIDC
//   i_vidc_tregs_status     status bit reflected in CONTROL readback
//   o_vidc_tregs_ack        MCU-driven level (CONTROL bit 2)
//   o_a_*                   active timing/config fields
//   o_is_hires              copy of o_a_hires
module video_cfg_bank #(
    parameter int TW     = 11,
    parameter int WPL_W  = 9,
    parameter int CURS_W = 11,
    parameter int N_PROF = 4,
    parameter int FC_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    video_cfg_bank_if.slave   bus,
    input  logic              i_sync_flybk,
    input  logic              i_vidc_tregs_status,
    output logic              o_vidc_tregs_ack,
    output logic [TW-1:0]     o_a_res_x,
    output logic [TW-1:0]     o_a_hs_fp,
    output logic [TW-1:0]     o_a_hs_width,
    output logic [TW-1:0]     o_a_hs_bp,
    output logic [TW-1:0]     o_a_res_y,
    output logic [TW-1:0]     o_a_vs_fp,
    output logic [TW-1:0]     o_a_vs_width,
    output logic [TW-1:0]     o_a_vs_bp,
    output logic [WPL_W-1:0]  o_a_wpl_m1,
    output logic [2:0]        o_a_bpp,
    output logic              o_a_hires,
    output logic              o_a_double_x,
    output logic              o_a_double_y,
    output logic              o_a_crtlook,
    output logic              o_a_ext_pal,
    output logic [CURS_W-1:0] o_a_cursor_x_off,
    output logic              o_is_hires
);
    localparam int PW = (N_PROF > 2) ? $clog2(N_PROF) : 1;

    typedef struct packed {
        logic [TW-1:0]     res_x, hs_fp, hs_width, hs_bp;
        logic [TW-1:0]     res_y, vs_fp, vs_width, vs_bp;
        logic [WPL_W-1:0]  wpl_m1;
        logic [2:0]        bpp;
        logic              hires, dbl_x, dbl_y, crtlook, ext_pal;
        logic [CURS_W-1:0] curs_off;
    } cfg_t;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_COPY, S_REQ, S_RELEASE} state_t;

    function automatic cfg_t cfg_default();
        cfg_t c;
        c.res_x    = TW'(640);
        c.hs_fp    = TW'(40);
        c.hs_width = TW'(20);
        c.hs_bp    = TW'(68);
        c.res_y    = TW'(256);
        c.vs_fp    = TW'(40);
        c.vs_width = TW'(5);
        c.vs_bp    = TW'(67);
        c.wpl_m1   = WPL_W'(79);
        c.bpp      = 3'd2;
        c.hires    = 1'b0;
        c.dbl_x    = 1'b0;
        c.dbl_y    = 1'b1;
        c.crtlook  = 1'b0;
        c.ext_pal  = 1'b0;
        c.curs_off = CURS_W'(217);
        return c;
    endfunction

    state_t          r_state;
    cfg_t            r_shadow [N_PROF];
    cfg_t            r_active;
    logic [PW-1:0]   r_wr_prof, r_act_prof, r_lat_prof;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_err, r_tregs_ack, r_req;
    logic            r_fb_s1, r_fb_s2, r_fb_d;

    logic [3:0]  w_idx;
    logic        w_wr, w_rise, w_ctrl_wr, w_commit, w_cprof_ok, w_wprof_ok;
    logic        w_busy, w_pending;
    logic [3:0]  w_cprof;
    logic [31:0] w_rd;
    cfg_t        w_sel;
    logic        w_unused;

    assign w_idx      = bus.reg_addr[5:2];
    assign w_wr       = bus.reg_wstrobe;
    assign w_rise     = r_fb_s2 & ~r_fb_d;
    assign w_ctrl_wr  = w_wr && (w_idx == 4'h8);
    assign w_commit   = w_ctrl_wr && bus.reg_wdata[0];
    assign w_cprof    = bus.reg_wdata[11:8];
    assign w_cprof_ok = int'(w_cprof) < N_PROF;
    // Compare the whole word so out-of-range values cannot alias after truncation.
    assign w_wprof_ok = bus.reg_wdata < 32'(N_PROF);
    assign w_busy     = (r_state == S_COPY) || (r_state == S_REQ) || (r_state == S_RELEASE);
    assign w_pending  = (r_state == S_ARMED);
    assign w_sel      = r_shadow[r_wr_prof];
    assign w_unused   = &{1'b0, bus.reg_addr[1:0], bus.reg_wdata};

    // Shadow profile writes. A write in the COPY cycle lands here only; COPY
    // samples the pre-edge shadow value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_PROF; i++) r_shadow[i] <= cfg_default();
        end else if (w_wr) begin
            case (w_idx)
                4'h0: begin
                    r_shadow[r_wr_prof].res_x <= bus.reg_wdata[TW-1:0];
                    r_shadow[r_wr_prof].dbl_x <= bus.reg_wdata[31];
                end
                4'h1: r_shadow[r_wr_prof].hs_fp    <= bus.reg_wdata[TW-1:0];
                4'h2: r_shadow[r_wr_prof].hs_width <= bus.reg_wdata[TW-1:0];
                4'h3: r_shadow[r_wr_prof].hs_bp    <= bus.reg_wdata[TW-1:0];
                4'h4: begin
                    r_shadow[r_wr_prof].res_y   <= bus.reg_wdata[TW-1:0];
                    r_shadow[r_wr_prof].crtlook <= bus.reg_wdata[30];
                    r_shadow[r_wr_prof].dbl_y   <= bus.reg_wdata[31];
                end
                4'h5: r_shadow[r_wr_prof].vs_fp    <= bus.reg_wdata[TW-1:0];
                4'h6: r_shadow[r_wr_prof].vs_width <= bus.reg_wdata[TW-1:0];
                4'h7: r_shadow[r_wr_prof].vs_bp    <= bus.reg_wdata[TW-1:0];
                4'h9: r_shadow[r_wr_prof].wpl_m1   <= bus.reg_wdata[WPL_W-1:0];
                // Mode word: hires[31], ext_pal[30], bpp[29:27], cursor offset low bits.
                4'hA: begin
                    r_shadow[r_wr_prof].hires    <= bus.reg_wdata[31];
                    r_shadow[r_wr_prof].ext_pal  <= bus.reg_wdata[30];
                    r_shadow[r_wr_prof].bpp      <= bus.reg_wdata[29:27];
                    r_shadow[r_wr_prof].curs_off <= bus.reg_wdata[CURS_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Control, flyback synchroniser, commit FSM and active set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_active    <= cfg_default();
            r_wr_prof   <= '0;
            r_act_prof  <= '0;
            r_lat_prof  <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
            r_tregs_ack <= 1'b0;
            r_req       <= 1'b0;
            r_fb_s1     <= 1'b0;
            r_fb_s2     <= 1'b0;
            r_fb_d      <= 1'b0;
        end else begin
            r_fb_s1 <= i_sync_flybk;
            r_fb_s2 <= r_fb_s1;
            r_fb_d  <= r_fb_s2;
            if (w_rise) r_frame_cnt <= r_frame_cnt + FC_W'(1);

            if (w_wr && (w_idx == 4'hB) && w_wprof_ok) r_wr_prof <= bus.reg_wdata[PW-1:0];

            if (w_ctrl_wr) begin
                r_tregs_ack <= bus.reg_wdata[2];
                if (bus.reg_wdata[3]) r_err <= 1'b0;
            end

            // Error sets below are placed after the clear so a set wins.
            case (r_state)
                S_IDLE: begin
                    if (w_commit) begin
                        if (w_cprof_ok) begin
                            r_lat_prof <= w_cprof[PW-1:0];
                            r_state    <= bus.reg_wdata[1] ? S_COPY : S_ARMED;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                // A rise coincident with the arming write was seen while IDLE, so
                // only a later rise advances from here.
                S_ARMED: if (w_rise) r_state <= S_COPY;
                S_COPY: begin
                    r_active   <= r_shadow[r_lat_prof];
                    r_act_prof <= r_lat_prof;
                    r_req      <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    if (bus.cfg_update_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: if (!bus.cfg_update_ack) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_commit && (r_state != S_IDLE)) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_idx)
            4'h0: begin w_rd[TW-1:0] = w_sel.res_x; w_rd[31] = w_sel.dbl_x; end
            4'h1: w_rd[TW-1:0] = w_sel.hs_fp;
            4'h2: w_rd[TW-1:0] = w_sel.hs_width;
            4'h3: w_rd[TW-1:0] = w_sel.hs_bp;
            4'h4: begin
                w_rd[TW-1:0] = w_sel.res_y;
                w_rd[30]     = w_sel.crtlook;
                w_rd[31]     = w_sel.dbl_y;
            end
            4'h5: w_rd[TW-1:0] = w_sel.vs_fp;
            4'h6: w_rd[TW-1:0] = w_sel.vs_width;
            4'h7: w_rd[TW-1:0] = w_sel.vs_bp;
            4'h8: w_rd[5:0] = {r_fb_s2, i_vidc_tregs_status, r_err, r_tregs_ack, w_busy, w_pending};
            4'h9: w_rd[WPL_W-1:0] = w_sel.wpl_m1;
            4'hA: begin
                w_rd[31]         = w_sel.hires;
                w_rd[30]         = w_sel.ext_pal;
                w_rd[29:27]      = w_sel.bpp;
                w_rd[CURS_W-1:0] = w_sel.curs_off;
            end
            4'hB: begin w_rd[PW-1:0] = r_wr_prof; w_rd[PW+15:16] = r_act_prof; end
            4'hC: w_rd[FC_W-1:0] = r_frame_cnt;
            default: w_rd = '0;
        endcase
    end

    assign bus.reg_rdata      = w_rd;
    assign bus.cfg_update_req = r_req;
    assign o_vidc_tregs_ack   = r_tregs_ack;
    assign o_a_res_x          = r_active.res_x;
    assign o_a_hs_fp          = r_active.hs_fp;
    assign o_a_hs_width       = r_active.hs_width;
    assign o_a_hs_bp          = r_active.hs_bp;
    assign o_a_res_y          = r_active.res_y;
    assign o_a_vs_fp          = r_active.vs_fp;
    assign o_a_vs_width       = r_active.vs_width;
    assign o_a_vs_bp          = r_active.vs_bp;
    assign o_a_wpl_m1         = r_active.wpl_m1;
    assign o_a_bpp            = r_active.bpp;
    assign o_a_hires          = r_active.hires;
    assign o_a_double_x       = r_active.dbl_x;
    assign o_a_double_y       = r_active.dbl_y;
    assign o_a_crtlook        = r_active.crtlook;
    assign o_a_ext_pal        = r_active.ext_pal;
    assign o_a_cursor_x_off   = r_active.curs_off;
    assign o_is_hires         = r_active.hires;
endmodule

// File: tb/tb_video_cfg_bank.sv
// Testbench for video_cfg_bank: randomized register traffic and commits checked
// against a register-image reference model. Frame counter is built narrow so its
// wrap is reachable in a short run.
module tb_video_cfg_bank;
    localparam int TW = 11, WPL_W = 9, CURS_W = 11, N_PROF = 4, FC_W = 4;
    localparam logic [31:0] TWM = 32'h7FF, WPLM = 32'h1FF, CURSM = 32'h7FF;

    logic clk = 1'b0;
    logic reset, sync_flybk, tstat;
    logic tregs_ack;
    logic [TW-1:0] a_res_x, a_hs_fp, a_hs_width, a_hs_bp, a_res_y, a_vs_fp, a_vs_width, a_vs_bp;
    logic [WPL_W-1:0] a_wpl_m1;
    logic [2:0] a_bpp;
    logic a_hires, a_double_x, a_double_y, a_crtlook, a_ext_pal, is_hires;
    logic [CURS_W-1:0] a_curs;

    always #5 clk = ~clk;

    video_cfg_bank_if bus();

    video_cfg_bank #(.TW(TW), .WPL_W(WPL_W), .CURS_W(CURS_W), .N_PROF(N_PROF), .FC_W(FC_W)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus), .i_sync_flybk(sync_flybk),
        .i_vidc_tregs_status(tstat), .o_vidc_tregs_ack(tregs_ack),
        .o_a_res_x(a_res_x), .o_a_hs_fp(a_hs_fp), .o_a_hs_width(a_hs_width), .o_a_hs_bp(a_hs_bp),
        .o_a_res_y(a_res_y), .o_a_vs_fp(a_vs_fp), .o_a_vs_width(a_vs_width), .o_a_vs_bp(a_vs_bp),
        .o_a_wpl_m1(a_wpl_m1), .o_a_bpp(a_bpp), .o_a_hires(a_hires), .o_a_double_x(a_double_x),
        .o_a_double_y(a_double_y), .o_a_crtlook(a_crtlook), .o_a_ext_pal(a_ext_pal),
        .o_a_cursor_x_off(a_curs), .o_is_hires(is_hires)
    );

    int n_checks = 0, n_errors = 0;

    // Reference model: per-profile readback images indexed by register number.
    logic [31:0] m_sh [N_PROF][11];
    logic [31:0] m_act [11];
    int m_wr_prof, m_act_prof, m_fc;
    bit m_err, m_tack;

    function automatic logic [31:0] fmask(int r);
        case (r)
            0:             return 32'h8000_0000 | TWM;
            1, 2, 3, 5, 6, 7: return TWM;
            4:             return 32'hC000_0000 | TWM;
            9:             return WPLM;
            10:            return 32'hF800_0000 | CURSM;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rst_img(int r);
        case (r)
            0: return 32'd640;        1: return 32'd40;  2: return 32'd20;  3: return 32'd68;
            4: return 32'h8000_0100;  5: return 32'd40;  6: return 32'd5;   7: return 32'd67;
            9: return 32'd79;         10: return 32'h1000_00D9;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < N_PROF; p++)
            for (int r = 0; r < 11; r++) m_sh[p][r] = rst_img(r);
        for (int r = 0; r < 11; r++) m_act[r] = rst_img(r);
        m_wr_prof = 0; m_act_prof = 0; m_fc = 0; m_err = 0; m_tack = 0;
    endtask

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wstrobe = 1'b1;
        @(negedge clk);
        bus.reg_wstrobe = 1'b0;
    endtask

    // Register write that also updates the model (not for CONTROL).
    task automatic mwr(input logic [5:0] a, input logic [31:0] d);
        int idx;
        wr(a, d);
        idx = int'(a[5:2]);
        if (idx <= 7 || idx == 9 || idx == 10) m_sh[m_wr_prof][idx] = d & fmask(idx);
        else if (idx == 11 && d < N_PROF) m_wr_prof = int'(d);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        bus.reg_addr = a;
        #1;
        chk_val(tag, bus.reg_rdata, exp);
    endtask

    task automatic chk_ctrl(input string tag, input bit busy, input bit pend);
        rd_chk(tag, 6'h20, {26'h0, 1'b0, tstat, m_err, m_tack, busy, pend});
    endtask

    task automatic chk_profsel(input string tag);
        rd_chk(tag, 6'h2C, (32'(m_act_prof) << 16) | 32'(m_wr_prof));
    endtask

    task automatic chk_active(input string tag);
        chk_val({tag, ".res_x"},    32'(a_res_x),    m_act[0] & TWM);
        chk_val({tag, ".hs_fp"},    32'(a_hs_fp),    m_act[1]);
        chk_val({tag, ".hs_width"}, 32'(a_hs_width), m_act[2]);
        chk_val({tag, ".hs_bp"},    32'(a_hs_bp),    m_act[3]);
        chk_val({tag, ".res_y"},    32'(a_res_y),    m_act[4] & TWM);
        chk_val({tag, ".vs_fp"},    32'(a_vs_fp),    m_act[5]);
        chk_val({tag, ".vs_width"}, 32'(a_vs_width), m_act[6]);
        chk_val({tag, ".vs_bp"},    32'(a_vs_bp),    m_act[7]);
        chk_val({tag, ".wpl"},      32'(a_wpl_m1),   m_act[9]);
        chk_val({tag, ".curs"},     32'(a_curs),     m_act[10] & CURSM);
        chk_val({tag, ".mode"},
                32'({a_bpp, a_hires, a_double_x, a_double_y, a_crtlook, a_ext_pal, is_hires}),
                32'({m_act[10][29:27], m_act[10][31], m_act[0][31], m_act[4][31],
                     m_act[4][30], m_act[10][30], m_act[10][31]}));
    endtask

    // Flyback while ARMED: active holds through the COPY cycle, then switches.
    task automatic fly_copy(input int p);
        @(negedge clk) sync_flybk = 1'b1;
        repeat (3) @(negedge clk);
        chk_active("hold");
        for (int r = 0; r < 11; r++) m_act[r] = m_sh[p][r];
        m_act_prof = p;
        m_fc++;
        @(negedge clk);
        chk_active("copy");
        chk_val("req_after_copy", 32'(bus.cfg_update_req), 32'd1);
        sync_flybk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fly_only();
        @(negedge clk) sync_flybk = 1'b1;
        repeat (2) @(negedge clk);
        sync_flybk = 1'b0;
        repeat (3) @(negedge clk);
        m_fc++;
    endtask

    task automatic handshake();
        chk_val("req_hold", 32'(bus.cfg_update_req), 32'd1);
        bus.cfg_update_ack = 1'b1;
        @(negedge clk);
        chk_val("req_drop", 32'(bus.cfg_update_req), 32'd0);
        chk_ctrl("ctrl_release", 1'b1, 1'b0);
        bus.cfg_update_ack = 1'b0;
        @(negedge clk);
        chk_ctrl("ctrl_idle", 1'b0, 1'b0);
        chk_profsel("profsel_done");
    endtask

    task automatic commit(input int p, input bit imm);
        bit tk;
        tk = 1'($urandom_range(0, 1));
        wr(6'h20, {20'h0, 4'(p), 5'b0, tk, imm, 1'b1});
        m_tack = tk;
        chk_val("tregs_ack_out", 32'(tregs_ack), 32'(m_tack));
        if (imm) begin
            chk_active("imm_hold");
            for (int r = 0; r < 11; r++) m_act[r] = m_sh[p][r];
            m_act_prof = p;
            @(negedge clk);
            chk_active("imm_copy");
        end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk_ctrl("ctrl_armed", 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                int r;
                r = (($urandom_range(0, 9)) > 7) ? 10 - ($urandom_range(0, 1)) : $urandom_range(0, 7);
                mwr(6'h2C, 32'(p));
                mwr(6'(r << 2), $urandom);
            end
            fly_copy(p);
        end
        handshake();
    endtask

    int regs [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 10};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, r;
        logic [31:0] d;
        reset = 1'b1; sync_flybk = 1'b0; tstat = 1'b0;
        bus.reg_wdata = '0; bus.reg_addr = '0; bus.reg_wstrobe = 1'b0; bus.cfg_update_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset state against literal values
        rd_chk("rst_res_x", 6'h00, 32'h0000_0280);
        rd_chk("rst_res_y", 6'h10, 32'h8000_0100);
        rd_chk("rst_mode",  6'h28, 32'h1000_00D9);
        rd_chk("rst_ctrl",  6'h20, 32'h0);
        chk_val("rst_req", 32'(bus.cfg_update_req), 32'd0);
        chk_val("rst_a_res_x", 32'(a_res_x), 32'd640);
        chk_active("rst");

        // Worked example: profile 2, flyback-synchronous commit
        mwr(6'h2C, 32'd2);
        mwr(6'h00, 32'h8000_0480);
        wr(6'h20, 32'h201);
        repeat (5) @(negedge clk);
        chk_val("ex_hold_res_x", 32'(a_res_x), 32'd640);
        chk_ctrl("ex_pending", 1'b0, 1'b1);
        fly_copy(2);
        chk_val("ex_res_x", 32'(a_res_x), 32'd1152);
        chk_val("ex_dbl_x", 32'(a_double_x), 32'd1);
        handshake();

        // Immediate commit leaves frame count alone
        rd_chk("fc_before_imm", 6'h30, 32'(m_fc % 16));
        commit(2, 1'b1);
        rd_chk("fc_after_imm", 6'h30, 32'(m_fc % 16));

        // Second commit while ARMED is rejected with sticky err
        wr(6'h20, 32'h201);
        m_tack = 0;
        wr(6'h20, 32'h301);
        m_err = 1;
        chk_ctrl("err_set", 1'b0, 1'b1);
        wr(6'h20, 32'h008);
        m_err = 0;
        chk_ctrl("err_clr", 1'b0, 1'b1);
        fly_copy(2);
        handshake();

        // Commit in the same cycle as a flyback rise waits for the next rise
        mwr(6'h2C, 32'd1);
        mwr(6'h00, $urandom);
        @(negedge clk) sync_flybk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.reg_addr = 6'h20; bus.reg_wdata = 32'h101; bus.reg_wstrobe = 1'b1;
        @(negedge clk);
        bus.reg_wstrobe = 1'b0; sync_flybk = 1'b0;
        m_tack = 0; m_fc++;
        repeat (3) @(negedge clk);
        chk_active("coinc_hold");
        chk_ctrl("coinc_pending", 1'b0, 1'b1);
        fly_copy(1);
        handshake();

        // Frame counter wrap
        rd_chk("fc_count", 6'h30, 32'(m_fc % 16));
        while ((m_fc % 16) != 15) fly_only();
        rd_chk("fc_max", 6'h30, 32'hF);
        fly_only();
        rd_chk("fc_wrap", 6'h30, 32'h0);

        // Out-of-range profile selects
        mwr(6'h2C, 32'd7);
        chk_profsel("profsel_bad");
        wr(6'h20, 32'h501);
        m_tack = 0; m_err = 1;
        chk_ctrl("bad_commit", 1'b0, 1'b0);
        wr(6'h20, 32'h008);
        m_err = 0;

        // Unmapped addresses and status passthrough
        wr(6'h34, 32'hFFFF_FFFF);
        rd_chk("unmapped_34", 6'h34, 32'h0);
        rd_chk("unmapped_38", 6'h38, 32'h0);
        rd_chk("unmapped_3c", 6'h3C, 32'h0);
        tstat = 1'b1;
        chk_ctrl("status_pass", 1'b0, 1'b0);

        // Randomized shadow traffic with readback
        for (int i = 0; i < 60; i++) begin
            p = $urandom_range(0, N_PROF - 1);
            r = regs[$urandom_range(0, 9)];
            d = $urandom;
            mwr(6'h2C, 32'(p));
            mwr(6'(r << 2), d);
            r = regs[$urandom_range(0, 9)];
            rd_chk("shadow_rd", 6'(r << 2), m_sh[m_wr_prof][r]);
        end

        // Randomized commits
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                mwr(6'h2C, 32'($urandom_range(0, N_PROF - 1)));
                r = regs[$urandom_range(0, 9)];
                mwr(6'(r << 2), $urandom);
            end
            commit($urandom_range(0, N_PROF - 1), 1'($urandom_range(0, 1)));
        end
        rd_chk("fc_final", 6'h30, 32'(m_fc % 16));

        // Reset in the middle of the handshake
        wr(6'h20, {20'h0, 4'd3, 8'h03});
        @(negedge clk);
        chk_val("mid_req", 32'(bus.cfg_update_req), 32'd1);
        bus.cfg_update_ack = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk_val("rst_mid_req", 32'(bus.cfg_update_req), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk_ctrl("rst_mid_ctrl", 1'b0, 1'b0);
        bus.cfg_update_ack = 1'b0;
        @(negedge clk);
        chk_active("rst_mid");
        chk_profsel("rst_mid_profsel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
